// File: rtl/onehot_encoder_fifo.sv
// One-hot to binary encoder feeding a first-word-fall-through FIFO, with a saturating reject counter.
// Optional macro ONEHOT_ENC_PRIORITY_EN: multi-bit words are encoded by highest set bit and flagged.
module onehot_encoder_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERRW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_onehot,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [2:0]              out_code,
    output logic                    out_multi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [ERRW-1:0]         err_cnt,
    output logic                    err_sticky,
    input  logic                    err_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic            err_sticky_q, err_sticky_d;
    logic [2:0]      code_mem_q [DEPTH];

    logic [2:0] hi_idx;
    logic       is_zero;
    logic       is_single;
    logic       encodable;
    logic       accept;
    logic       push;
    logic       pop;
    logic       err_evt;

    // Highest set bit; for a one-hot word this is its index.
    always_comb begin
        hi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_onehot[i]) hi_idx = 3'(i);
        end
    end

    assign is_zero   = (in_onehot == 8'h00);
    assign is_single = !is_zero && ((in_onehot & (in_onehot - 8'd1)) == 8'h00);

`ifdef ONEHOT_ENC_PRIORITY_EN
    assign encodable = !is_zero;
`else
    assign encodable = is_single;
`endif

    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != LW'(0));
    assign accept    = in_valid && in_ready;
    assign push      = accept && encodable;
    assign pop       = out_valid && out_ready;
    assign err_evt   = accept && !encodable;

    // Next-state for pointers, occupancy and error tracking.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        // Clear wins over an error arriving in the same cycle.
        if (err_clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (err_evt) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Storage is reset so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) code_mem_q[i] <= 3'd0;
        end else if (push) begin
            code_mem_q[wr_ptr_q] <= hi_idx;
        end
    end

`ifdef ONEHOT_ENC_PRIORITY_EN
    logic multi_mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) multi_mem_q[i] <= 1'b0;
        end else if (push) begin
            multi_mem_q[wr_ptr_q] <= !is_single;
        end
    end

    assign out_multi = multi_mem_q[rd_ptr_q];
`else
    assign out_multi = 1'b0;
`endif

    assign out_code   = code_mem_q[rd_ptr_q];
    assign level      = level_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_onehot_encoder_fifo.sv
// Directed bench for onehot_encoder_fifo (DEPTH=4, ERRW=2 so saturation is reachable).
module tb_onehot_encoder_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ERRW  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_onehot = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       in_ready;
    logic [2:0] out_code;
    logic       out_multi;
    logic       out_valid;
    logic [2:0] level;
    logic [ERRW-1:0] err_cnt;
    logic       err_sticky;

    int checks = 0;
    int errors = 0;

    onehot_encoder_fifo #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_onehot  (in_onehot),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_code   (out_code),
        .out_multi  (out_multi),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_codes [5];
    logic [2:0] expq [$];
    logic [7:0] one8;
    int sent;
    int rcvd;
    bit do_push;
    bit do_pop;

    initial begin
        exp_codes[0] = 3'd0; exp_codes[1] = 3'd1; exp_codes[2] = 3'd2;
        exp_codes[3] = 3'd3; exp_codes[4] = 3'd7;

        // Reset values
        #1 rst_n = 1'b0;
        #20;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_iready", 32'(in_ready), 32'd1);
        chk("rst_code", 32'(out_code), 32'd0);
        chk("rst_multi", 32'(out_multi), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Single word, one-cycle latency then drained
        in_onehot = 8'b0010_0000; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_ovalid", 32'(out_valid), 32'd1);
        chk("lat_code", 32'(out_code), 32'd5);
        chk("lat_multi", 32'(out_multi), 32'd0);
        tick();
        chk("drain_ovalid", 32'(out_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);

        // Fill to full, fifth word held off, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            one8 = 8'h01;
            in_onehot = one8 << i; in_valid = 1'b1;
            tick();
        end
        in_onehot = 8'h80;
        chk("full_level", 32'(level), 32'd4);
        chk("full_iready", 32'(in_ready), 32'd0);
        tick();
        chk("held_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("order_valid", 32'(out_valid), 32'd1);
            chk("order_code", 32'(out_code), 32'(exp_codes[i]));
            tick();
            if (i == 0) chk("pop_nopush_lvl", 32'(level), 32'd3);
            if (i == 1) begin
                chk("pushpop_lvl", 32'(level), 32'd3);
                in_valid = 1'b0;
            end
        end
        chk("order_empty", 32'(out_valid), 32'd0);
        chk("order_level", 32'(level), 32'd0);

        // Zero word rejected, then cleared
        in_onehot = 8'h00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("zero_level", 32'(level), 32'd0);
        chk("zero_errcnt", 32'(err_cnt), 32'd1);
        chk("zero_sticky", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_errcnt", 32'(err_cnt), 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);

        // Clear beats a coincident error
        in_valid = 1'b1; err_clr = 1'b1;
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        chk("clrprio_errcnt", 32'(err_cnt), 32'd0);
        chk("clrprio_sticky", 32'(err_sticky), 32'd0);

        // Multi-bit word
        out_ready = 1'b0;
        in_onehot = 8'b1000_0100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ONEHOT_ENC_PRIORITY_EN
        chk("multi_valid", 32'(out_valid), 32'd1);
        chk("multi_code", 32'(out_code), 32'd7);
        chk("multi_flag", 32'(out_multi), 32'd1);
        chk("multi_errcnt", 32'(err_cnt), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`else
        chk("multi_valid", 32'(out_valid), 32'd0);
        chk("multi_errcnt", 32'(err_cnt), 32'd1);
        chk("multi_sticky", 32'(err_sticky), 32'd1);
`endif
        chk("multi_level", 32'(level), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Saturation: five rejects into a 2-bit counter
        in_onehot = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        chk("sat_errcnt", 32'(err_cnt), 32'd3);
        chk("sat_sticky", 32'(err_sticky), 32'd1);

        // Asynchronous reset mid-stream with level=2
        in_onehot = 8'h01; in_valid = 1'b1;
        tick();
        in_onehot = 8'h02;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ovalid", 32'(out_valid), 32'd0);
        chk("arst_iready", 32'(in_ready), 32'd1);
        chk("arst_errcnt", 32'(err_cnt), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst_level", 32'(level), 32'd0);

        // Continuous stream with out_ready toggling, against a queue model
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 200 && rcvd < 16; cyc++) begin
            out_ready = cyc[0];
            in_valid  = (sent < 16);
            one8 = 8'h01;
            in_onehot = one8 << (sent % 8);
            chk("str_iready", 32'(in_ready), 32'(expq.size() < DEPTH));
            chk("str_ovalid", 32'(out_valid), 32'(expq.size() > 0));
            chk("str_level", 32'(level), 32'(expq.size()));
            if (expq.size() > 0) chk("str_code", 32'(out_code), 32'(expq[0]));
            do_push = in_valid && (expq.size() < DEPTH);
            do_pop  = (expq.size() > 0) && out_ready;
            if (do_pop) begin
                void'(expq.pop_front());
                rcvd++;
            end
            if (do_push) begin
                expq.push_back(3'(sent % 8));
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("str_received", 32'(rcvd), 32'd16);
        chk("str_end_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
